// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction fetch / data) to one-slave Wishbone B4 classic arbiter.
// Data wins contention unless round-robin fairness is enabled; a watchdog ends hung cycles with an error.
module mem_bus_arbiter #(
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        iwbs_cyc_i,
    input  logic        iwbs_stb_i,
    input  logic [31:0] iwbs_addr_i,
    output logic        iwbs_ack_o,
    output logic        iwbs_err_o,
    output logic [31:0] iwbs_dat_o,
    input  logic        dwbs_cyc_i,
    input  logic        dwbs_stb_i,
    input  logic        dwbs_we_i,
    input  logic [3:0]  dwbs_sel_i,
    input  logic [31:0] dwbs_addr_i,
    input  logic [31:0] dwbs_dat_i,
    output logic        dwbs_ack_o,
    output logic        dwbs_err_o,
    output logic [31:0] dwbs_dat_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;   // 1 = data was granted last, 0 = instruction
    logic [15:0] cnt_q, cnt_d;

    logic req_i, req_d;
    logic owner_cyc;
    logic ack_fwd, err_fwd, fire;

    assign req_i = iwbs_cyc_i & iwbs_stb_i;
    assign req_d = dwbs_cyc_i & dwbs_stb_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_sel_o  = 4'h0;
        wbm_addr_o = 32'h0;
        wbm_dat_o  = 32'h0;
        owner_cyc  = 1'b0;
        ack_fwd    = 1'b0;
        err_fwd    = 1'b0;
        fire       = 1'b0;

        case (state_q)
            IDLE: begin
                // Data takes contention unless fairness says instruction is owed a turn.
                if (req_d && (!req_i || ROUND_ROBIN == 0 || !last_q)) begin
                    state_d = GNT_D;
                    last_d  = 1'b1;
                    cnt_d   = 16'd0;
                end else if (req_i) begin
                    state_d = GNT_I;
                    last_d  = 1'b0;
                    cnt_d   = 16'd0;
                end
            end
            GNT_I: begin
                wbm_cyc_o  = 1'b1;
                wbm_stb_o  = 1'b1;
                wbm_sel_o  = 4'hF;
                wbm_addr_o = iwbs_addr_i;
                owner_cyc  = iwbs_cyc_i;
            end
            GNT_D: begin
                wbm_cyc_o  = 1'b1;
                wbm_stb_o  = 1'b1;
                wbm_we_o   = dwbs_we_i;
                wbm_sel_o  = dwbs_sel_i;
                wbm_addr_o = dwbs_addr_i;
                wbm_dat_o  = dwbs_dat_i;
                owner_cyc  = dwbs_cyc_i;
            end
            default: state_d = IDLE;
        endcase

        // Termination is common to both grant states; an aborting master gets nothing.
        if (state_q == GNT_I || state_q == GNT_D) begin
            if (!owner_cyc) begin
                state_d = IDLE;
            end else if (wbm_ack_i || wbm_err_i) begin
                ack_fwd = wbm_ack_i;
                err_fwd = wbm_err_i;
                state_d = IDLE;
            end else if (WDOG_EN && cnt_q == CNT_LAST) begin
                err_fwd = 1'b1;
                fire    = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // A reset cycle suppresses any termination that would otherwise reach a master.
    assign iwbs_ack_o = (state_q == GNT_I) & ack_fwd & ~rst_i;
    assign iwbs_err_o = (state_q == GNT_I) & err_fwd & ~rst_i;
    assign dwbs_ack_o = (state_q == GNT_D) & ack_fwd & ~rst_i;
    assign dwbs_err_o = (state_q == GNT_D) & err_fwd & ~rst_i;
    assign timeout_o  = fire & ~rst_i;
    assign grant_o    = {state_q == GNT_D, state_q == GNT_I};
    assign iwbs_dat_o = wbm_dat_i;
    assign dwbs_dat_o = wbm_dat_i;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (round-robin/T=4 and fixed-priority/T=1) share stimulus
// and are compared every cycle against a transaction-level owner/age model.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, icyc, istb, dcyc, dstb, dwe, ack, err;
    logic [3:0]  dsel;
    logic [31:0] iaddr, daddr, dwdat, sdat;

    logic        iack [2], ierr [2], dack [2], derr [2];
    logic        mcyc [2], mstb [2], mwe [2], tmo [2];
    logic [3:0]  msel [2];
    logic [31:0] idat [2], ddat [2], maddr [2], mdat [2];
    logic [1:0]  grant [2];

    mem_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .iwbs_cyc_i(icyc), .iwbs_stb_i(istb), .iwbs_addr_i(iaddr),
        .iwbs_ack_o(iack[0]), .iwbs_err_o(ierr[0]), .iwbs_dat_o(idat[0]),
        .dwbs_cyc_i(dcyc), .dwbs_stb_i(dstb), .dwbs_we_i(dwe), .dwbs_sel_i(dsel),
        .dwbs_addr_i(daddr), .dwbs_dat_i(dwdat),
        .dwbs_ack_o(dack[0]), .dwbs_err_o(derr[0]), .dwbs_dat_o(ddat[0]),
        .wbm_cyc_o(mcyc[0]), .wbm_stb_o(mstb[0]), .wbm_we_o(mwe[0]), .wbm_sel_o(msel[0]),
        .wbm_addr_o(maddr[0]), .wbm_dat_o(mdat[0]),
        .wbm_ack_i(ack), .wbm_err_i(err), .wbm_dat_i(sdat),
        .grant_o(grant[0]), .timeout_o(tmo[0])
    );

    mem_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(1)) u_fp (
        .clk_i(clk), .rst_i(rst),
        .iwbs_cyc_i(icyc), .iwbs_stb_i(istb), .iwbs_addr_i(iaddr),
        .iwbs_ack_o(iack[1]), .iwbs_err_o(ierr[1]), .iwbs_dat_o(idat[1]),
        .dwbs_cyc_i(dcyc), .dwbs_stb_i(dstb), .dwbs_we_i(dwe), .dwbs_sel_i(dsel),
        .dwbs_addr_i(daddr), .dwbs_dat_i(dwdat),
        .dwbs_ack_o(dack[1]), .dwbs_err_o(derr[1]), .dwbs_dat_o(ddat[1]),
        .wbm_cyc_o(mcyc[1]), .wbm_stb_o(mstb[1]), .wbm_we_o(mwe[1]), .wbm_sel_o(msel[1]),
        .wbm_addr_o(maddr[1]), .wbm_dat_o(mdat[1]),
        .wbm_ack_i(ack), .wbm_err_i(err), .wbm_dat_i(sdat),
        .grant_o(grant[1]), .timeout_o(tmo[1])
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: owner 0 = nobody, 1 = instruction, 2 = data; waited = grant cycles already spent.
    int rr_p [2]  = '{1, 0};
    int tmo_p [2] = '{4, 1};
    int owner [2], waited [2], last [2];

    bit capture = 1'b0;
    int gq0 [$];
    int gq1 [$];
    int to_seen = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k]  = 0;
            waited[k] = 0;
            last[k]   = 1;
        end
    endtask

    // Check both instances against the model for the current cycle, then advance one clock.
    task automatic tick();
        int nxt_o [2], nxt_w [2], nxt_l [2];
        #4;
        for (int k = 0; k < 2; k++) begin
            logic [70:0] eb, ob;
            logic [6:0]  er, orsp;
            logic        mc, t_ack, t_err, t_to;
            bit          ri, rd;
            string       kind;
            eb = '0; er = '0; kind = "";
            t_ack = 1'b0; t_err = 1'b0; t_to = 1'b0;
            nxt_o[k] = owner[k]; nxt_w[k] = waited[k]; nxt_l[k] = last[k];
            if (owner[k] == 1) begin
                eb = {1'b1, 1'b1, 1'b0, 4'hF, iaddr, 32'h0};
                er[1:0] = 2'b01;
            end else if (owner[k] == 2) begin
                eb = {1'b1, 1'b1, dwe, dsel, daddr, dwdat};
                er[1:0] = 2'b10;
            end
            if (rst) begin
                nxt_o[k] = 0; nxt_w[k] = 0; nxt_l[k] = 1;
            end else if (owner[k] == 0) begin
                ri = icyc && istb;
                rd = dcyc && dstb;
                if (ri && rd) nxt_o[k] = (rr_p[k] != 0 && last[k] == 2) ? 1 : 2;
                else if (rd)  nxt_o[k] = 2;
                else if (ri)  nxt_o[k] = 1;
                if (nxt_o[k] != 0) begin
                    nxt_l[k] = nxt_o[k];
                    nxt_w[k] = 0;
                end
            end else begin
                mc = (owner[k] == 1) ? icyc : dcyc;
                if (!mc) begin
                    nxt_o[k] = 0; kind = "abort";
                end else if (ack || err) begin
                    t_ack = ack; t_err = err; nxt_o[k] = 0;
                    kind = err ? "err" : "ack";
                end else if (tmo_p[k] != 0 && waited[k] + 1 == tmo_p[k]) begin
                    t_err = 1'b1; t_to = 1'b1; nxt_o[k] = 0; kind = "timeout";
                end else begin
                    nxt_w[k] = waited[k] + 1;
                end
                if (owner[k] == 1) er[6:5] = {t_ack, t_err};
                else               er[4:3] = {t_ack, t_err};
                er[2] = t_to;
            end
            ob   = {mcyc[k], mstb[k], mwe[k], msel[k], maddr[k], mdat[k]};
            orsp = {iack[k], ierr[k], dack[k], derr[k], tmo[k], grant[k]};
            check_val($sformatf("bus%0d", k), 128'(ob), 128'(eb));
            check_val($sformatf("resp%0d", k), 128'(orsp), 128'(er));
            check_val($sformatf("rdat%0d", k), 128'({idat[k], ddat[k]}), 128'({sdat, sdat}));
            if (kind != "")
                $display("txn inst=%0d master=%s end=%s addr=%h t=%0t", k,
                         (owner[k] == 1) ? "instr" : "data", kind,
                         (owner[k] == 1) ? iaddr : daddr, $time);
            if (capture && grant[k] != 2'b00) begin
                if (k == 0 && (gq0.size() == 0 || mcyc[k] && owner[k] != 0)) gq0.push_back(int'(grant[k]));
                if (k == 1 && (gq1.size() == 0 || mcyc[k] && owner[k] != 0)) gq1.push_back(int'(grant[k]));
            end
            if (capture && tmo[k] && k == 0) to_seen++;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            owner[k] = nxt_o[k]; waited[k] = nxt_w[k]; last[k] = nxt_l[k];
        end
    endtask

    task automatic quiet();
        icyc = 0; istb = 0; dcyc = 0; dstb = 0; dwe = 0; ack = 0; err = 0;
    endtask

    function automatic logic [127:0] pack4(input int q [$]);
        logic [127:0] v = '0;
        for (int i = 0; i < 4; i++) v = (v << 4) | 128'((i < q.size()) ? q[i] : 15);
        return v;
    endfunction

    initial begin
        rst = 1; quiet();
        iaddr = 0; daddr = 0; dwdat = 0; dsel = 0; sdat = 32'hA5A5_0001;
        @(posedge clk); #1;
        model_reset();
        tick();                           // reset state
        rst = 0;

        // Instruction-only read of 0x8000_0000, slave acks in the second grant cycle.
        icyc = 1; istb = 1; iaddr = 32'h8000_0000;
        tick(); tick();
        ack = 1; sdat = 32'h1234_5678;
        tick();
        quiet(); tick(); tick();

        // Both masters request continuously from reset with an always-acking slave.
        rst = 1; tick(); rst = 0;
        icyc = 1; istb = 1; dcyc = 1; dstb = 1; ack = 1;
        capture = 1;
        for (int i = 0; i < 9; i++) tick();
        capture = 0;
        check_val("rr_order", pack4(gq0), 128'h2121);
        check_val("fp_order", pack4(gq1), 128'h2222);
        dcyc = 0; dstb = 0;
        for (int i = 0; i < 3; i++) tick();

        // Reset during an instruction grant, then simultaneous request after release.
        quiet(); tick(); tick();
        icyc = 1; istb = 1; tick();
        rst = 1; tick();
        rst = 0; dcyc = 1; dstb = 1; tick(); tick();

        // Data write with a silent slave: watchdog must fire exactly once in this window.
        quiet(); tick(); tick();
        dcyc = 1; dstb = 1; dwe = 1; daddr = 32'h100; dsel = 4'b0011; dwdat = 32'hDEAD_BEEF;
        capture = 1; to_seen = 0;
        for (int i = 0; i < 7; i++) tick();
        capture = 0;
        check_val("timeout_pulses", 128'(to_seen), 128'd1);

        // Data drops cyc while the slave acks, with an instruction request pending.
        quiet(); tick(); tick();
        dcyc = 1; dstb = 1; dwe = 0; tick();
        icyc = 1; istb = 1; dcyc = 0; dstb = 0; ack = 1; tick();
        ack = 0; tick(); tick();

        // Randomized traffic.
        quiet();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) icyc = ~icyc;
            istb = icyc & ($urandom_range(7) != 0);
            if ($urandom_range(3) == 0) iaddr = $urandom;
            if ($urandom_range(7) == 0) dcyc = ~dcyc;
            dstb = dcyc & ($urandom_range(7) != 0);
            if ($urandom_range(3) == 0) begin
                daddr = $urandom; dwdat = $urandom;
                dsel = 4'($urandom); dwe = 1'($urandom);
            end
            ack  = ($urandom_range(3) == 0);
            err  = ($urandom_range(15) == 0);
            sdat = $urandom;
            rst  = ($urandom_range(127) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
